// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory address and
// the IF/ID pipeline register, with stall hold, redirect with one-bubble
// penalty, halt detection on a sentinel word, and a delivered-fetch counter.
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [31:0] NOP_WORD  = 32'h00000000,
  parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic [31:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [31:0] id_instr,
  output logic [15:0] id_pc4,
  output logic        id_valid,
  output logic        halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] pc_plus4;

  // pc is kept word-aligned, so +4 never disturbs bits [1:0]; wraps mod 2^16
  assign pc_plus4 = pc_q + 16'd4;

  // State register plus IF/ID register; reset dominates everything
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= {RESET_PC[15:2], 2'b00};
      instr_q <= NOP_WORD;
      pc4_q   <= 16'h0000;
      valid_q <= 1'b0;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: redirect beats halt/stall, halt beats stall, else advance
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      // The word fetched this cycle is from the wrong path: drop it
      state_d = RUN;
      pc_d    = {redirect_pc[15:2], 2'b00};
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (state_q == HALT) begin
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else if (stall) begin
      // hold everything
    end else if (imem_data == HALT_WORD) begin
      // pc stays on the halt word so the display shows where fetch stopped
      state_d = HALT;
      instr_d = NOP_WORD;
      valid_d = 1'b0;
    end else begin
      instr_d = imem_data;
      pc4_d   = pc_plus4;
      valid_d = 1'b1;
      pc_d    = pc_plus4;
      cnt_d   = cnt_q + 16'd1;
    end
  end

  assign imem_addr   = pc_q;
  assign id_instr    = instr_q;
  assign id_pc4      = pc4_q;
  assign id_valid    = valid_q;
  assign halted      = (state_q == HALT);
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a behavioural model of the fetch
// rules runs alongside the DUT against a synthetic instruction memory.
module tb_fetch_stage;
  localparam logic [31:0] HALT_W = 32'hFC000000;

  logic        clock = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [31:0] imem_data = 32'h0;
  logic [15:0] imem_addr, id_pc4, fetch_count;
  logic [31:0] id_instr;
  logic        id_valid, halted;

  int checks = 0;
  int errors = 0;

  fetch_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_data(imem_data), .imem_addr(imem_addr),
    .id_instr(id_instr), .id_pc4(id_pc4), .id_valid(id_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  always #5 clock = ~clock;

  // Memory image: fixed program words at 0/4/8, halt word at halt_addr,
  // address-derived words elsewhere (never zero, never the halt word).
  logic [15:0] halt_addr = 16'hFFFF;
  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    if (a === halt_addr) return HALT_W;
    case (a)
      16'h0000: return 32'h20010001;
      16'h0004: return 32'h20020002;
      16'h0008: return 32'h20030003;
      default:  return {a ^ 16'h5A5A, a};
    endcase
  endfunction

  // Reference model state
  logic [15:0] m_pc, m_pc4, m_cnt;
  logic [31:0] m_instr;
  logic        m_valid, m_halted;

  logic [81:0] obs, expv;
  assign obs = {imem_addr, id_instr, id_pc4, id_valid, halted, fetch_count};
  function automatic logic [81:0] model_vec();
    return {m_pc, m_instr, m_pc4, m_valid, m_halted, m_cnt};
  endfunction

  // One clock: memory answers on the falling edge, model and DUT update on
  // the rising edge, caller compares 1 time unit later.
  task automatic step();
    logic [31:0] w;
    @(negedge clock);
    imem_data = mem_rd(imem_addr);
    @(posedge clock);
    w = mem_rd(m_pc);
    if (reset) begin
      m_pc = 16'h0; m_instr = 32'h0; m_pc4 = 16'h0;
      m_valid = 1'b0; m_halted = 1'b0; m_cnt = 16'h0;
    end else if (redirect) begin
      m_pc = redirect_pc & 16'hFFFC; m_instr = 32'h0; m_valid = 1'b0;
      m_halted = 1'b0;
    end else if (m_halted) begin
      m_instr = 32'h0; m_valid = 1'b0;
    end else if (stall) begin
    end else if (w == HALT_W) begin
      m_halted = 1'b1; m_instr = 32'h0; m_valid = 1'b0;
    end else begin
      m_instr = w; m_pc = m_pc + 16'd4; m_pc4 = m_pc; m_valid = 1'b1;
      m_cnt = m_cnt + 16'd1;
    end
    #1;
    expv = model_vec();
  endtask

  task automatic drive(input logic r, input logic s, input logic rd, input logic [15:0] rp);
    reset = r; stall = s; redirect = rd; redirect_pc = rp;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 16'h0); step();
    checks++;
    if (obs !== {16'h0, 32'h0, 16'h0, 1'b0, 1'b0, 16'h0}) begin
      errors++; $display("FAIL reset_values got %h want all-zero", obs);
    end
    drive(0, 0, 0, 16'h0);
  endtask

  task automatic test_basic();
    for (int i = 0; i < 3; i++) begin
      step(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL basic[%0d] got %h want %h", i, obs, expv); end
    end
    checks++;
    if ({id_instr, id_pc4, id_valid, fetch_count} !== {32'h20030003, 16'h000C, 1'b1, 16'd3}) begin
      errors++; $display("FAIL basic_end got %h/%h/%b/%0d want 20030003/000c/1/3",
                         id_instr, id_pc4, id_valid, fetch_count);
    end
  endtask

  task automatic test_stall();
    // pc is 0x0C here; back up to 0x8 via the stall scenario is not possible,
    // so restart at 0 and stall with pc at 0x8
    drive(1, 0, 0, 16'h0); step(); drive(0, 0, 0, 16'h0);
    step(); step();
    drive(0, 1, 0, 16'h0);
    for (int i = 0; i < 2; i++) begin
      step(); checks++;
      if (obs !== expv || imem_addr !== 16'h0008 || fetch_count !== 16'd2) begin
        errors++; $display("FAIL stall[%0d] got %h want %h", i, obs, expv);
      end
    end
    drive(0, 0, 0, 16'h0); step(); checks++;
    if (obs !== expv || id_instr !== 32'h20030003 || imem_addr !== 16'h000C) begin
      errors++; $display("FAIL stall_release got %h want %h", obs, expv);
    end
  endtask

  task automatic test_redirect();
    step(); // pc 0x0C -> 0x10
    drive(0, 1, 1, 16'h0043); step(); checks++;
    if (obs !== expv || imem_addr !== 16'h0040 || id_valid !== 1'b0 || id_instr !== 32'h0) begin
      errors++; $display("FAIL redirect_bubble got %h want %h", obs, expv);
    end
    drive(0, 0, 0, 16'h0); step(); checks++;
    if (obs !== expv || id_instr !== mem_rd(16'h0040) || id_pc4 !== 16'h0044) begin
      errors++; $display("FAIL redirect_target got %h want %h", obs, expv);
    end
  endtask

  task automatic test_halt();
    logic [15:0] cnt_at_halt;
    int n = 0;
    halt_addr = 16'h0020;
    drive(0, 0, 1, 16'h0010); step(); drive(0, 0, 0, 16'h0);
    while (!halted && n < 20) begin
      step(); n++; checks++;
      if (obs !== expv) begin errors++; $display("FAIL halt_run got %h want %h", obs, expv); end
    end
    checks++;
    if (halted !== 1'b1 || imem_addr !== 16'h0020 || id_valid !== 1'b0) begin
      errors++; $display("FAIL halt_enter halted=%b pc=%h valid=%b want 1/0020/0", halted, imem_addr, id_valid);
    end
    cnt_at_halt = fetch_count;
    drive(0, 1, 0, 16'h0); step(); drive(0, 0, 0, 16'h0); step(); step();
    checks++;
    if (obs !== expv || fetch_count !== cnt_at_halt || imem_addr !== 16'h0020) begin
      errors++; $display("FAIL halt_hold got %h want %h", obs, expv);
    end
    drive(0, 0, 1, 16'h0000); step(); drive(0, 0, 0, 16'h0); step(); checks++;
    if (obs !== expv || halted !== 1'b0 || id_instr !== 32'h20010001 || imem_addr !== 16'h0004) begin
      errors++; $display("FAIL halt_resume got %h want %h", obs, expv);
    end
    halt_addr = 16'hFFFF;
  endtask

  task automatic test_reset_mid();
    halt_addr = 16'h0008;
    drive(1, 0, 0, 16'h0); step(); drive(0, 0, 0, 16'h0);
    for (int i = 0; i < 4; i++) step();
    drive(1, 1, 0, 16'h0); step(); checks++;
    if (obs !== 82'h0) begin errors++; $display("FAIL reset_while_halted got %h want 0", obs); end
    drive(0, 0, 0, 16'h0); step(); step();
    drive(1, 0, 1, 16'h1234); step(); checks++;
    if (obs !== 82'h0) begin errors++; $display("FAIL reset_during_redirect got %h want 0", obs); end
    halt_addr = 16'hFFFF;
    drive(0, 0, 0, 16'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) halt_addr = 16'($urandom_range(0, 31) * 4);
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) == 0, 16'($urandom_range(0, 16'h7F)));
      step(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL random[%0d] got %h want %h", i, obs, expv); end
    end
    halt_addr = 16'hFFFF;
    drive(0, 0, 0, 16'h0);
  endtask

  task automatic test_wrap();
    drive(0, 0, 1, 16'hFFF9); step(); drive(0, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step(); checks++;
      if (obs !== expv) begin errors++; $display("FAIL pc_wrap[%0d] got %h want %h", i, obs, expv); end
    end
    checks++;
    if (imem_addr !== 16'h0004 || id_pc4 !== 16'h0004) begin
      errors++; $display("FAIL pc_wrap_end pc=%h pc4=%h want 0004/0004", imem_addr, id_pc4);
    end
    // fetch_count wraps after 65536 deliveries
    drive(1, 0, 0, 16'h0); step(); drive(0, 0, 0, 16'h0);
    for (int i = 0; i < 65536; i++) begin
      step();
      if ((i & 4095) == 4095) begin
        checks++;
        if (obs !== expv) begin errors++; $display("FAIL count_run[%0d] got %h want %h", i, obs, expv); end
      end
    end
    checks++;
    if (fetch_count !== 16'h0000 || imem_addr !== 16'h0000 || id_valid !== 1'b1) begin
      errors++; $display("FAIL count_wrap cnt=%h pc=%h valid=%b want 0000/0000/1", fetch_count, imem_addr, id_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_halt();
    test_reset_mid();
    test_random();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
